// File: rtl/harvard_mem_pkg.sv
// rtl/harvard_mem_pkg.sv - shared types and helpers for the Harvard memory controller
package harvard_mem_pkg;

  typedef enum logic {CLEAR, RUN} mem_state_t;

  localparam int MAX_DW = 256;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Callers widen to MAX_DW and truncate the result back to their word width.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_DW/8-1:0] mask);
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int k = 0; k < MAX_DW/8; k++) begin
      if (mask[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/harvard_mem_resp.sv
// rtl/harvard_mem_resp.sv - one-cycle response register for a single memory port
module harvard_mem_resp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  accept,
  input  logic [DATA_WIDTH-1:0] rdata_next,
  input  logic                  err_next,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= accept;
      if (accept) begin
        rdata <= rdata_next;
        err   <= err_next;
      end
    end
  end

endmodule

// File: rtl/harvard_mem_ctrl.sv
// rtl/harvard_mem_ctrl.sv - shared word RAM with read-only i-port and byte-masked d-port
// HARVARD_MEM_BYPASS_EN forwards a same-cycle d-write into a colliding i-read.
module harvard_mem_ctrl
  import harvard_mem_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 64,
  parameter int    ADDR_WIDTH = 30,
  parameter string FILE       = ""
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_err,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err,
  output logic                    init_done
);

  localparam int IW = idx_width(DEPTH);

  mem_state_t            state;
  logic [IW-1:0]         clear_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  i_acc, d_acc, i_inr, d_inr, d_wr;
  logic [IW-1:0]         i_idx, d_idx;
  logic [DATA_WIDTH-1:0] i_old, d_old, d_merged, i_next, d_next;

  assign i_ready = (state == RUN);
  assign d_ready = (state == RUN);
  assign i_acc   = i_valid && i_ready;
  assign d_acc   = d_valid && d_ready;
  assign i_inr   = (i_addr < ADDR_WIDTH'(DEPTH));
  assign d_inr   = (d_addr < ADDR_WIDTH'(DEPTH));
  assign i_idx   = i_addr[IW-1:0];
  assign d_idx   = d_addr[IW-1:0];
  assign d_wr    = d_acc && d_inr && (d_wmask != '0);
  assign i_old   = mem[i_idx];
  assign d_old   = mem[d_idx];
  assign d_merged = DATA_WIDTH'(byte_merge(MAX_DW'(d_old), MAX_DW'(d_wdata),
                                           (MAX_DW/8)'(d_wmask)));

`ifdef HARVARD_MEM_BYPASS_EN
  assign i_next = !i_inr ? '0 : (d_wr && (d_idx == i_idx)) ? d_merged : i_old;
`else
  assign i_next = i_inr ? i_old : '0;
`endif
  assign d_next = (!d_inr || (d_wmask != '0)) ? '0 : d_old;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= (FILE == "") ? CLEAR : RUN;
      clear_cnt <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clear_cnt == IW'(DEPTH - 1)) begin
            clear_cnt <= '0;
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            clear_cnt <= clear_cnt + IW'(1);
          end
        end
        RUN:     init_done <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

  // Array has no reset; the clear sequencer is the only path that zeroes it.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state == CLEAR) mem[clear_cnt] <= '0;
      else if (d_wr)      mem[d_idx]     <= d_merged;
    end
  end

  harvard_mem_resp #(.DATA_WIDTH(DATA_WIDTH)) u_i_resp (
    .clk(clk), .resetn(resetn), .accept(i_acc), .rdata_next(i_next), .err_next(!i_inr),
    .rvalid(i_rvalid), .rdata(i_rdata), .err(i_err)
  );

  harvard_mem_resp #(.DATA_WIDTH(DATA_WIDTH)) u_d_resp (
    .clk(clk), .resetn(resetn), .accept(d_acc), .rdata_next(d_next), .err_next(!d_inr),
    .rvalid(d_rvalid), .rdata(d_rdata), .err(d_err)
  );

endmodule

// File: tb/tb_harvard_mem_ctrl.sv
// tb/tb_harvard_mem_ctrl.sv - scoreboard bench for harvard_mem_ctrl against a word-array model
module tb_harvard_mem_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, d_valid;
  logic [29:0] i_addr, d_addr;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic        i_ready, d_ready, i_rvalid, d_rvalid, i_err, d_err, init_done;
  logic [31:0] i_rdata, d_rdata;

  harvard_mem_ctrl dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wmask(d_wmask),
    .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] mdl [64];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  function automatic void clear_model();
    for (int k = 0; k < 64; k++) mdl[k] = '0;
  endfunction

  // Monitor: every response is popped and compared, including its arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      last_i = '0;
      last_d = '0;
    end else begin
      if (i_rvalid) begin
        if (iq.size() == 0) chk("i_unexpected_rvalid", 1, 0);
        else begin
          e = iq.pop_front();
          chk("i_rdata", i_rdata, e.data);
          chk("i_err", {31'd0, i_err}, {31'd0, e.err});
          chk("i_latency", cyc, e.cyc);
        end
        last_i = i_rdata;
      end else chk("i_rdata_hold", i_rdata, last_i);
      if (d_rvalid) begin
        if (dq.size() == 0) chk("d_unexpected_rvalid", 1, 0);
        else begin
          e = dq.pop_front();
          chk("d_rdata", d_rdata, e.data);
          chk("d_err", {31'd0, d_err}, {31'd0, e.err});
          chk("d_latency", cyc, e.cyc);
        end
        last_d = d_rdata;
      end else chk("d_rdata_hold", d_rdata, last_d);
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic step(input logic iv, input logic [29:0] ia, input logic dv,
                      input logic [29:0] da, input logic [3:0] dm, input logic [31:0] dw);
    exp_t e;
    logic d_write;
    @(posedge clk);
    #1;
    i_valid = iv; i_addr = ia; d_valid = dv; d_addr = da; d_wmask = dm; d_wdata = dw;
    @(negedge clk);
    d_write = dv && d_ready && (da < 64) && (dm != 4'd0);
    if (iv && i_ready) begin
      e.err  = (ia >= 64);
      e.data = e.err ? 32'd0 : mdl[ia[5:0]];
`ifdef HARVARD_MEM_BYPASS_EN
      if (d_write && (da == ia)) e.data = merge(mdl[ia[5:0]], dw, dm);
`endif
      e.cyc = cyc + 1;
      iq.push_back(e);
    end
    if (dv && d_ready) begin
      e.err  = (da >= 64);
      e.data = (e.err || dm != 4'd0) ? 32'd0 : mdl[da[5:0]];
      e.cyc  = cyc + 1;
      dq.push_back(e);
      if (d_write) mdl[da[5:0]] = merge(mdl[da[5:0]], dw, dm);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_i_rvalid", {31'd0, i_rvalid}, 0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 0);
    chk("rst_i_err", {31'd0, i_err}, 0);
    chk("rst_d_err", {31'd0, d_err}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_init_done", {31'd0, init_done}, 0);
    chk("rst_i_ready", {31'd0, i_ready}, 0);
  endtask

  // Release reset with i_valid held on addr; count the cycles the request is refused.
  task automatic release_and_clear(input logic [29:0] addr);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk);
    #1;
    i_valid = 1'b1; i_addr = addr; resetn = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (i_ready) break;
      n++;
      chk("init_done_during_clear", {31'd0, init_done}, 0);
    end
    chk("clear_cycles", n, 64);
    chk("init_done_after_clear", {31'd0, init_done}, 1);
    clear_model();
    e.data = 32'd0;
    e.err  = 1'b0;
    e.cyc  = cyc + 1;
    iq.push_back(e);
    idle(2);
  endtask

  initial begin
    resetn = 1'b0;
    i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0; d_wmask = 0; d_wdata = 0;
    clear_model();
    repeat (3) @(negedge clk);
    check_reset_outputs();

    release_and_clear(30'd5);

    step(0, 0, 1, 3, 4'b1111, 32'hAABBCCDD);
    step(0, 0, 1, 3, 4'b0101, 32'h11223344);
    step(1, 3, 1, 3, 4'b0000, 32'h0);
    idle(1);

    step(1, 7, 1, 7, 4'b0011, 32'hDEADBEEF);
    step(1, 7, 0, 0, 0, 0);
    idle(1);

    step(0, 0, 1, 0, 4'b1111, 32'h0BADF00D);
    step(0, 0, 1, 64, 4'b1111, 32'hFFFFFFFF);
    step(0, 0, 1, 0, 4'b0000, 32'h0);
    step(1, 100, 1, 30'h3FFFFFFF, 4'b0000, 32'h0);
    step(1, 63, 1, 63, 4'b1000, 32'h5A000000);
    idle(1);

    for (int a = 0; a < 8; a++) step(0, 0, 1, a, 4'b1111, $urandom);
    for (int a = 0; a < 8; a++) step(1, a, 0, 0, 0, 0);
    idle(1);

    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 1), $urandom_range(0, 70), $urandom_range(0, 1),
           $urandom_range(0, 70), ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom), $urandom);
    end
    idle(3);

    release_and_clear_midway();

    for (int a = 0; a < 8; a++) step(1, a, 1, 63 - a, 4'd0, 0);
    idle(1);

    for (int k = 0; k < 10 && (iq.size() + dq.size()) != 0; k++) @(negedge clk);
    chk("scoreboard_drained", iq.size() + dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic release_and_clear_midway();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) @(negedge clk);
    chk("midclear_ready_low", {31'd0, i_ready}, 0);
    resetn = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    check_reset_outputs();
    release_and_clear(30'd9);
  endtask

endmodule
